// File: rtl/s641_bist_ctrl.sv
// BIST sequencer for the s641 core: flush, LFSR pattern stream on cut_pi, MISR compaction of cut_po.
// DONE follows the first BUSY cycle by INIT_CYCLES+N_PATTERNS+CAP_LAT cycles; no backpressure, start/done handshake only.
module s641_bist_ctrl #(
    parameter int              N_IN        = 35,
    parameter int              N_OUT       = 24,
    parameter int              N_PATTERNS  = 1024,
    parameter int              INIT_CYCLES = 4,
    parameter int              CAP_LAT     = 0,
    parameter logic [N_IN-1:0]  SEED        = 35'h000000001,
    parameter logic [N_IN-1:0]  POLY_IN     = 35'h000000005,
    parameter logic [N_OUT-1:0] POLY_OUT    = 24'h000087,
    parameter logic [N_IN-1:0]  INIT_VEC    = 35'h0
) (
    input  logic                        ck,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        abort,
    input  logic [N_OUT-1:0]            golden_sig,
    input  logic [N_OUT-1:0]            cut_po,
    output logic [N_IN-1:0]             cut_pi,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_OUT-1:0]            signature,
    output logic [$clog2(N_PATTERNS):0] pat_cnt
);

    localparam int PCW = $clog2(N_PATTERNS) + 1;
    localparam int CCW = $clog2(INIT_CYCLES + N_PATTERNS + CAP_LAT + 1);
    localparam int PW  = (CAP_LAT > 0) ? CAP_LAT : 1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CCW-1:0]   cyc;
    logic [N_IN-1:0]  lfsr, lfsr_nxt;
    logic [PW-1:0]    vpipe;
    logic [N_OUT-1:0] misr_nxt, sig_upd;
    logic             cap_vld, enter_init, enter_done;

    always_ff @(posedge ck) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // abort has priority over every other exit of a busy state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_INIT;
            S_INIT:  if (abort) state_nxt = S_IDLE;
                     else if (cyc == CCW'(INIT_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN:   if (abort) state_nxt = S_IDLE;
                     else if (cyc == CCW'(N_PATTERNS - 1))
                         state_nxt = (CAP_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (abort) state_nxt = S_IDLE;
                     else if (cyc == CCW'(CAP_LAT - 1)) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_INIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy       = (state == S_INIT) || (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign enter_init = (state_nxt == S_INIT) && (state != S_INIT);
    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    // capture strobe trails each RUN cycle by CAP_LAT cycles; an abort edge never captures
    assign cap_vld  = ((CAP_LAT == 0) ? (state == S_RUN) : vpipe[PW-1])
                      && busy && (state_nxt != S_IDLE);
    assign lfsr_nxt = {lfsr[N_IN-2:0], 1'b0} ^ (lfsr[N_IN-1] ? POLY_IN : '0);
    assign misr_nxt = {signature[N_OUT-2:0], 1'b0} ^ (signature[N_OUT-1] ? POLY_OUT : '0) ^ cut_po;
    assign sig_upd  = cap_vld ? misr_nxt : signature;

    always_ff @(posedge ck) begin
        if (!resetn) begin
            cyc       <= '0;
            lfsr      <= SEED;
            vpipe     <= '0;
            cut_pi    <= '0;
            signature <= '0;
            pat_cnt   <= '0;
            pass      <= 1'b0;
        end else begin
            cyc   <= (state_nxt != state) ? '0 : (busy ? cyc + 1'b1 : cyc);
            vpipe <= (state_nxt == S_IDLE) ? '0 : ((vpipe << 1) | PW'(state == S_RUN));
            case (state_nxt)
                S_RUN:           cut_pi <= lfsr;
                S_INIT, S_DRAIN: cut_pi <= INIT_VEC;
                default:         cut_pi <= '0;
            endcase
            if (enter_init) begin
                lfsr      <= SEED;
                signature <= '0;
                pat_cnt   <= '0;
                pass      <= 1'b0;
            end else begin
                if (state_nxt == S_RUN) lfsr <= lfsr_nxt;
                signature <= sig_upd;
                if ((state == S_RUN) && (pat_cnt != PCW'(N_PATTERNS))) pat_cnt <= pat_cnt + 1'b1;
                // the last capture lands on the same edge that enters DONE
                if (enter_done)              pass <= (sig_upd == golden_sig);
                else if (state_nxt != S_DONE) pass <= 1'b0;
            end
        end
    end

endmodule
